// File: rtl/ram_req_pkg.sv
// Shared types and default sizing for the single-port RAM responder.
// Holds the FSM state enum and the default ADDR_W/DATA_W/DEPTH values.
package ram_req_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD1,
    RD2,
    RESP
  } state_t;

endpackage

// File: rtl/ram_req_responder_if.sv
// Request/response bundle between an initiator and the RAM responder.
// master = initiator side, slave = responder side.
interface ram_req_responder_if
  import ram_req_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_was_wr;
  logic [7:0]        txn_count;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_was_wr, txn_count
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_was_wr, txn_count
  );

endinterface

// File: rtl/sp_mem_core.sv
// DEPTH x DATA_W storage: synchronous write, registered read, async clear.
// Ports: clk, rst (active-low), i_we, i_re, i_addr, i_wdata -> o_rdata.
module sp_mem_core #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_rdata <= '0;
    else if (i_re)
      r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_req_responder.sv
// Single-outstanding RAM request responder: FSM, req/rsp regs, txn counter.
// Ports: clk, rst (async active-low), bus (ram_req_responder_if.slave).
module ram_req_responder
  import ram_req_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_req_responder_if.slave    bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_was_wr;
  logic [7:0]        r_count;

  logic              w_accept;
  logic              w_done;
  logic              w_mem_we;
  logic              w_mem_re;
  logic              w_ld_wack;
  logic              w_ld_rd;
  logic [DATA_W-1:0] w_mem_q;

  sp_mem_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    w_mem_we  = 1'b0;
    w_mem_re  = 1'b0;
    w_ld_wack = 1'b0;
    w_ld_rd   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = bus.req_we ? WR : RD1;
        end
      end
      WR: begin
        w_mem_we  = r_we;
        w_ld_wack = 1'b1;
        w_next    = RESP;
      end
      RD1: begin
        w_mem_re = 1'b1;
        w_next   = RD2;
      end
      RD2: begin
        w_ld_rd = 1'b1;
        w_next  = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_was_wr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
      if (w_ld_wack) begin
        r_rdata  <= '0;
        r_was_wr <= 1'b1;
      end
      if (w_ld_rd) begin
        r_rdata  <= w_mem_q;
        r_was_wr <= 1'b0;
      end
      if (w_done)
        r_count <= r_count + 8'd1;
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_rdata  = r_rdata;
  assign bus.rsp_was_wr = r_was_wr;
  assign bus.txn_count  = r_count;

endmodule

// File: tb/tb_ram_req_responder.sv
// Self-checking bench for ram_req_responder with a transaction-level model.
// Randomized traffic, backpressure, abort-by-reset and counter wrap.
module tb_ram_req_responder;
  import ram_req_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ram_req_responder_if bus ();

  ram_req_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_mem [16];
  logic [7:0] m_count;
  logic [7:0] m_rdata;
  bit         m_wr;
  bit         m_ready;
  bit         m_valid;
  bit         mon_en = 1'b0;

  logic [7:0] got;
  bit         got_wr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      chk("txn_count", 32'(bus.txn_count), 32'(m_count));
      if (m_valid) begin
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rdata));
        chk("rsp_was_wr", 32'(bus.rsp_was_wr), 32'(m_wr));
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_count = 8'd0;
    m_valid = 1'b0;
    m_ready = 1'b1;
    m_rdata = 8'h00;
    m_wr    = 1'b0;
  endtask

  task automatic garble();
    bus.req_valid = 1'($urandom);
    bus.req_we    = 1'($urandom);
    bus.req_addr  = 4'($urandom);
    bus.req_wdata = 8'($urandom);
    bus.rsp_ready = 1'($urandom);
  endtask

  task automatic do_reset(input int cyc);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
    chk("rst_was_wr", 32'(bus.rsp_was_wr), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic txn(input bit we, input logic [3:0] a,
                     input logic [7:0] d, input int stall,
                     output logic [7:0] rd, output bit rw);
    int lat;
    lat = we ? 1 : 2;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.rsp_ready = 1'($urandom);
    @(posedge clk);
    m_ready = 1'b0;
    m_wr    = we;
    m_rdata = we ? 8'h00 : m_mem[a];
    if (we) m_mem[a] = d;
    #1 garble();
    for (int i = 0; i < lat; i++) begin
      @(posedge clk);
      if (i == lat - 1) m_valid = 1'b1;
      #1 garble();
    end
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    rd = bus.rsp_rdata;
    rw = bus.rsp_was_wr;
    repeat (stall) begin
      @(posedge clk);
      #1 garble();
      bus.rsp_ready = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    m_valid = 1'b0;
    m_ready = 1'b1;
    m_count = m_count + 8'd1;
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'h0;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b0;
    model_reset();
    #1;
    mon_en = 1'b1;

    do_reset(10);
    txn(1'b0, 4'h5, 8'h00, 0, got, got_wr);
    chk("first_read_data", 32'(got), 32'h00);
    chk("first_read_wr", 32'(got_wr), 32'h0);
    chk("first_read_cnt", 32'(bus.txn_count), 32'd1);

    txn(1'b1, 4'h3, 8'hA7, 0, got, got_wr);
    chk("wack_data", 32'(got), 32'h00);
    chk("wack_wr", 32'(got_wr), 32'h1);
    txn(1'b0, 4'h3, 8'h00, 0, got, got_wr);
    chk("wr_rd_data", 32'(got), 32'hA7);

    txn(1'b0, 4'h3, 8'h00, 5, got, got_wr);
    chk("bp_data", 32'(got), 32'hA7);
    chk("bp_cnt", 32'(bus.txn_count), 32'd4);

    do_reset(3);
    for (int i = 0; i < 20; i++)
      txn(1'b1, 4'($urandom), 8'($urandom), $urandom_range(0, 3),
          got, got_wr);
    for (int i = 0; i < 20; i++)
      txn(1'b0, 4'($urandom), 8'h00, $urandom_range(0, 3), got, got_wr);
    chk("rand_cnt", 32'(bus.txn_count), 32'd40);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'($urandom);
    @(posedge clk);
    m_ready = 1'b0;
    #1 garble();
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_cnt", 32'(bus.txn_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      txn(1'b0, 4'($urandom), 8'h00, 0, got, got_wr);
      chk("abort_read", 32'(got), 32'h00);
    end

    do_reset(2);
    for (int i = 0; i < 255; i++)
      txn(1'b1, 4'($urandom), 8'($urandom), 0, got, got_wr);
    chk("wrap_255", 32'(bus.txn_count), 32'd255);
    txn(1'b1, 4'($urandom), 8'($urandom), 0, got, got_wr);
    chk("wrap_0", 32'(bus.txn_count), 32'd0);

    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
